fast_command_decoder: RTL and testbench



---
 rtl/fast_command_decoder.sv | 148 ++++++++++++++
 tb/tb_fast_command_decoder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fast_command_decoder.sv
// rtl/fast_command_decoder.sv - fast command link receiver: frame alignment with lock hysteresis, command decode, error count
// Hunts for the 110xxxx1 header on a fixed 8-bit phase, then decodes in-phase frames while locked.
module fast_command_decoder #(
  parameter int         LOCK_THRESH   = 8,
  parameter int         UNLOCK_THRESH = 4,
  parameter logic       INVERT        = 1'b0,
  parameter logic [3:0] IDLE_PAYLOAD  = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fast_command_in,
  input  logic        err_count_clear,
  output logic        locked,
  output logic [2:0]  bit_phase,
  output logic        cmd_valid,
  output logic [3:0]  cmd,
  output logic        frame_valid,
  output logic        hdr_err,
  output logic [15:0] err_count
);
  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [5:0] LOCK_N   = 6'(LOCK_THRESH);
  localparam logic [5:0] UNLOCK_N = 6'(UNLOCK_THRESH);

  state_t      state_q;
  logic [7:0]  sr_q;
  logic [2:0]  bit_ctr_q;
  logic [2:0]  lock_phase_q;
  logic [5:0]  lock_count_q;
  logic [5:0]  miss_count_q;
  logic        cmd_valid_q;
  logic        frame_valid_q;
  logic        hdr_err_q;
  logic [3:0]  cmd_q;
  logic [15:0] err_count_q;

  logic        b;
  logic        hm;
  logic        bnd;
  logic [3:0]  payload;
  logic [5:0]  lock_count_d;
  logic [5:0]  miss_count_d;
  logic [15:0] err_count_d;

  assign b            = fast_command_in ^ INVERT;
  assign hm           = (sr_q[7:5] == 3'b110) && sr_q[0];
  assign payload      = sr_q[4:1];
  assign bnd          = (bit_ctr_q == lock_phase_q);
  assign lock_count_d = lock_count_q + 6'd1;
  assign miss_count_d = miss_count_q + 6'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SEARCH;
      sr_q          <= '0;
      bit_ctr_q     <= '0;
      lock_phase_q  <= '0;
      lock_count_q  <= '0;
      miss_count_q  <= '0;
      cmd_valid_q   <= 1'b0;
      frame_valid_q <= 1'b0;
      hdr_err_q     <= 1'b0;
      cmd_q         <= '0;
    end else begin
      sr_q          <= {sr_q[6:0], b};
      bit_ctr_q     <= bit_ctr_q + 3'd1;
      cmd_valid_q   <= 1'b0;
      frame_valid_q <= 1'b0;
      hdr_err_q     <= 1'b0;
      case (state_q)
        SEARCH: begin
          if (hm) begin
            lock_phase_q <= bit_ctr_q;
            lock_count_q <= 6'd1;
            state_q      <= VERIFY;
          end
        end
        VERIFY: begin
          if (bnd) begin
            if (hm) begin
              lock_count_q <= lock_count_d;
              if (lock_count_d == LOCK_N) begin
                state_q      <= LOCKED;
                miss_count_q <= '0;
              end
            end else begin
              lock_count_q <= '0;
              state_q      <= SEARCH;
            end
          end
        end
        LOCKED: begin
          // Off-phase matches are payload aliases and must not disturb alignment.
          if (bnd) begin
            frame_valid_q <= 1'b1;
            hdr_err_q     <= !hm;
            if (hm) begin
              miss_count_q <= '0;
              if (payload != IDLE_PAYLOAD) begin
                cmd_valid_q <= 1'b1;
                cmd_q       <= payload;
              end
            end else begin
              miss_count_q <= miss_count_d;
              if (miss_count_d == UNLOCK_N) begin
                state_q      <= SEARCH;
                lock_count_q <= '0;
              end
            end
          end
        end
        default: state_q <= SEARCH;
      endcase
    end
  end

  // Clear takes priority over a coincident increment.
  always_comb begin
    err_count_d = err_count_q;
    if (err_count_clear) begin
      err_count_d = '0;
    end else if (hdr_err_q && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign locked      = (state_q == LOCKED);
  assign bit_phase   = lock_phase_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd         = cmd_q;
  assign frame_valid = frame_valid_q;
  assign hdr_err     = hdr_err_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_fast_command_decoder.sv
// tb/tb_fast_command_decoder.sv - scoreboard bench for fast_command_decoder, plain and inverted-input instances
module tb_fast_command_decoder;
  localparam int LOCK_N = 8;

  typedef struct {
    int          cyc;
    logic [4:0]  m;
    logic        fv;
    logic        he;
    logic        cv;
    logic [3:0]  cmd;
    logic        lk;
    logic [2:0]  ph;
    logic [15:0] ec;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic fc_in = 1'b0;
  logic fc_in_n = 1'b1;
  logic err_clr = 1'b0;

  logic        lk_w  [2];
  logic [2:0]  ph_w  [2];
  logic        cv_w  [2];
  logic [3:0]  cmd_w [2];
  logic        fv_w  [2];
  logic        he_w  [2];
  logic [15:0] ec_w  [2];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int clr_cyc = -100;
  int force_cyc = -100;
  logic [3:0]  exp_cmd = 4'h0;
  logic [15:0] exp_ec = 16'h0;
  logic [2:0]  exp_ph = 3'd0;
  exp_t sb[$];

  fast_command_decoder dut_a (
    .clk(clk), .reset(reset), .fast_command_in(fc_in), .err_count_clear(err_clr),
    .locked(lk_w[0]), .bit_phase(ph_w[0]), .cmd_valid(cv_w[0]), .cmd(cmd_w[0]),
    .frame_valid(fv_w[0]), .hdr_err(he_w[0]), .err_count(ec_w[0])
  );

  fast_command_decoder #(.INVERT(1'b1)) dut_b (
    .clk(clk), .reset(reset), .fast_command_in(fc_in_n), .err_count_clear(err_clr),
    .locked(lk_w[1]), .bit_phase(ph_w[1]), .cmd_valid(cv_w[1]), .cmd(cmd_w[1]),
    .frame_valid(fv_w[1]), .hdr_err(he_w[1]), .err_count(ec_w[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        e = sb[i];
        if (e.cyc > cyc) continue;
        sb.delete(i);
        if (e.cyc < cyc) begin
          vectors++;
          miscompares++;
          $display("FAIL sb_stale: entry for cycle %0d still pending at cycle %0d", e.cyc, cyc);
          continue;
        end
        for (int d = 0; d < 2; d++) begin
          if (e.m[0]) begin
            vectors++;
            if ({fv_w[d], he_w[d], cv_w[d]} !== {e.fv, e.he, e.cv}) begin
              miscompares++;
              $display("FAIL strobes dut%0d cyc %0d: fv/he/cv got %b%b%b expected %b%b%b",
                       d, cyc, fv_w[d], he_w[d], cv_w[d], e.fv, e.he, e.cv);
            end
          end
          if (e.m[1]) begin
            vectors++;
            if (cmd_w[d] !== e.cmd) begin
              miscompares++;
              $display("FAIL cmd dut%0d cyc %0d: got %h expected %h", d, cyc, cmd_w[d], e.cmd);
            end
          end
          if (e.m[2]) begin
            vectors++;
            if (lk_w[d] !== e.lk) begin
              miscompares++;
              $display("FAIL locked dut%0d cyc %0d: got %b expected %b", d, cyc, lk_w[d], e.lk);
            end
          end
          if (e.m[3]) begin
            vectors++;
            if (ph_w[d] !== e.ph) begin
              miscompares++;
              $display("FAIL bit_phase dut%0d cyc %0d: got %0d expected %0d", d, cyc, ph_w[d], e.ph);
            end
          end
          if (e.m[4]) begin
            vectors++;
            if (ec_w[d] !== e.ec) begin
              miscompares++;
              $display("FAIL err_count dut%0d cyc %0d: got %h expected %h", d, cyc, ec_w[d], e.ec);
            end
          end
        end
      end
    end
  endtask

  task automatic drive_bit(input logic v);
    fc_in = v;
    fc_in_n = ~v;
    err_clr = (cyc == clr_cyc);
    if (cyc == force_cyc) begin
      force dut_a.err_count_q = 16'hFFFC;
      force dut_b.err_count_q = 16'hFFFC;
      #2;
      release dut_a.err_count_q;
      release dut_b.err_count_q;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fc_in = 1'b0;
    fc_in_n = 1'b1;
    err_clr = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_cmd = 4'h0;
    exp_ec = 16'h0;
    exp_ph = 3'd0;
    sb.push_back('{cyc, 5'h1F, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 16'h0});
  endtask

  // First bit of f sent first; strobes expected 9 cycles after that bit.
  task automatic send_frame(input logic [7:0] f, input logic fv, input logic he, input logic lk);
    int t;
    logic cv;
    t = cyc;
    cv = fv && !he && (f[4:1] != 4'h0);
    if (cv) exp_cmd = f[4:1];
    sb.push_back('{t + 9, 5'h0F, fv, he, cv, exp_cmd, lk, exp_ph, 16'h0});
    if (clr_cyc == t + 9) exp_ec = 16'h0;
    else if (fv && he && exp_ec != 16'hFFFF) exp_ec = exp_ec + 16'h1;
    sb.push_back('{t + 10, 5'h13, 1'b0, 1'b0, 1'b0, exp_cmd, lk, exp_ph, exp_ec});
    for (int i = 7; i >= 0; i--) drive_bit(f[i]);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fc_in = 1'($urandom_range(0, 1));
      fc_in_n = ~fc_in;
      @(posedge clk);
      #1;
    end
    do_reset();
    #3;
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if ({lk_w[d], ph_w[d], cv_w[d], cmd_w[d], fv_w[d], he_w[d], ec_w[d]} !== 27'h0) begin
        miscompares++;
        $display("FAIL reset_state dut%0d: got lk=%b ph=%0d cv=%b cmd=%h fv=%b he=%b ec=%h expected all 0",
                 d, lk_w[d], ph_w[d], cv_w[d], cmd_w[d], fv_w[d], he_w[d], ec_w[d]);
      end
    end
  endtask

  task automatic test_lock(input int p);
    int c;
    for (int i = 0; i < p; i++) drive_bit(1'b0);
    c = cyc + 8;
    exp_ph = 3'(p);
    sb.push_back('{c + 56, 5'h04, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 16'h0});
    sb.push_back('{c + 57, 5'h0C, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, exp_ph, 16'h0});
    for (int i = 0; i < LOCK_N + 2; i++) send_frame(8'hC1, i >= LOCK_N, 1'b0, i >= LOCK_N - 1);
  endtask

  task automatic test_command();
    send_frame(8'hCB, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) send_frame(8'hC1, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_alias();
    send_frame(8'hDB, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) send_frame(8'hC1, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_errors();
    send_frame(8'h41, 1'b1, 1'b1, 1'b1);
    send_frame(8'hC1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send_frame(8'h41, 1'b1, 1'b1, i < 3);
    flush(2);
  endtask

  task automatic test_midlock_reset();
    do_reset();
    test_lock(3);
    for (int i = 0; i < 7; i++) begin
      send_frame(8'h41, 1'b1, 1'b1, 1'b1);
      send_frame(8'hC1, 1'b1, 1'b0, 1'b1);
    end
    #3;
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (ec_w[d] !== 16'd7 || lk_w[d] !== 1'b1) begin
        miscompares++;
        $display("FAIL pre_reset dut%0d: got ec=%h lk=%b expected ec=0007 lk=1", d, ec_w[d], lk_w[d]);
      end
    end
    flush(2);
    do_reset();
    test_lock(0);
  endtask

  task automatic test_saturation();
    force_cyc = cyc + 3;
    exp_ec = 16'hFFFC;
    send_frame(8'hC1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      send_frame(8'h41, 1'b1, 1'b1, 1'b1);
      send_frame(8'hC1, 1'b1, 1'b0, 1'b1);
    end
    #3;
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (ec_w[d] !== 16'hFFFF) begin
        miscompares++;
        $display("FAIL saturate dut%0d: got %h expected ffff", d, ec_w[d]);
      end
    end
    clr_cyc = cyc + 9;
    send_frame(8'h41, 1'b1, 1'b1, 1'b1);
    send_frame(8'hC1, 1'b1, 1'b0, 1'b1);
    send_frame(8'hC1, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    fork
      monitor_loop();
    join_none
    test_reset();
    test_lock(0);
    test_command();
    test_alias();
    test_errors();
    test_midlock_reset();
    test_saturation();
    flush(4);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: got %0d pending entries expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
